// File: rtl/craps_pkg.sv
// rtl/craps_pkg.sv - shared status encodings and default rule sums for the craps engine
package craps_pkg;

    localparam logic [1:0] ST_COME_OUT = 2'b00;
    localparam logic [1:0] ST_POINT    = 2'b01;
    localparam logic [1:0] ST_WIN      = 2'b10;
    localparam logic [1:0] ST_LOSE     = 2'b11;

    localparam int BLANK_DIE = 0;

    localparam int DEF_NAT_A     = 7;
    localparam int DEF_NAT_B     = 11;
    localparam int DEF_CRAPS_A   = 2;
    localparam int DEF_CRAPS_B   = 3;
    localparam int DEF_CRAPS_C   = 12;
    localparam int DEF_SEVEN_OUT = 7;

endpackage

// File: rtl/dice_counter_chain.sv
// rtl/dice_counter_chain.sv - cascaded free-running die counters, each 1..DIE_FACES
module dice_counter_chain
    import craps_pkg::*;
#(
    parameter  int NUM_DICE  = 2,
    parameter  int DIE_FACES = 6,
    localparam int DIE_W     = $clog2(DIE_FACES + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [NUM_DICE*DIE_W-1:0] dice_o
);

    logic [NUM_DICE-1:0][DIE_W-1:0] die_q, die_d;
    logic                           carry;

    // A die only steps when every lower die wrapped this cycle; die 0 always steps.
    always_comb begin
        die_d = die_q;
        carry = 1'b1;
        for (int i = 0; i < NUM_DICE; i++) begin
            if (carry) begin
                if (die_q[i] == DIE_W'(DIE_FACES)) begin
                    die_d[i] = DIE_W'(1);
                end else begin
                    die_d[i] = die_q[i] + DIE_W'(1);
                    carry    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            die_q <= {NUM_DICE{DIE_W'(1)}};
        end else begin
            die_q <= die_d;
        end
    end

    assign dice_o = die_q;

endmodule

// File: rtl/craps_engine_n.sv
// rtl/craps_engine_n.sv - parametrised craps engine: roll sync, 3-stage evaluation, tallies
module craps_engine_n
    import craps_pkg::*;
#(
    parameter  int NUM_DICE  = 2,
    parameter  int DIE_FACES = 6,
    parameter  int NAT_A     = DEF_NAT_A,
    parameter  int NAT_B     = DEF_NAT_B,
    parameter  int CRAPS_A   = DEF_CRAPS_A,
    parameter  int CRAPS_B   = DEF_CRAPS_B,
    parameter  int CRAPS_C   = DEF_CRAPS_C,
    parameter  int SEVEN_OUT = DEF_SEVEN_OUT,
    parameter  int CNT_W     = 8,
    localparam int DIE_W     = $clog2(DIE_FACES + 1),
    localparam int SUM_W     = $clog2(NUM_DICE * DIE_FACES + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      roll,
    input  logic                      force_en,
    input  logic [NUM_DICE*DIE_W-1:0] force_dice,
    output logic [NUM_DICE*DIE_W-1:0] dice,
    output logic [SUM_W-1:0]          sum,
    output logic [SUM_W-1:0]          point,
    output logic [1:0]                status,
    output logic                      win,
    output logic                      loss,
    output logic                      busy,
    output logic [CNT_W-1:0]          roll_count,
    output logic [CNT_W-1:0]          win_count,
    output logic [CNT_W-1:0]          loss_count
);

    logic                      sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic                      stage1_q, stage1_d, stage2_q, stage2_d;
    logic [NUM_DICE*DIE_W-1:0] dice_q, dice_d, chain_dice;
    logic [SUM_W-1:0]          sum_q, sum_d, point_q, point_d;
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          roll_count_q, roll_count_d;
    logic [CNT_W-1:0]          win_count_q, win_count_d;
    logic [CNT_W-1:0]          loss_count_q, loss_count_d;
    logic                      roll_pulse, accept, is_natural, is_craps;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    dice_counter_chain #(
        .NUM_DICE  (NUM_DICE),
        .DIE_FACES (DIE_FACES)
    ) u_chain (
        .clock  (clock),
        .reset  (reset),
        .dice_o (chain_dice)
    );

    assign roll_pulse = sync2_q & ~edge_q;
    assign busy       = stage1_q | stage2_q;
    assign accept     = roll_pulse & ~busy;

    always_comb begin
        sync1_d  = roll;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        stage1_d = accept;
        stage2_d = stage1_q;
        dice_d   = dice_q;
        if (accept) begin
            dice_d = force_en ? force_dice : chain_dice;
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (stage1_q) begin
            sum_d = '0;
            for (int i = 0; i < NUM_DICE; i++) begin
                sum_d = sum_d + SUM_W'(dice_q[i*DIE_W +: DIE_W]);
            end
        end
    end

    assign is_natural = (sum_q == SUM_W'(NAT_A)) || (sum_q == SUM_W'(NAT_B));
    assign is_craps   = (sum_q == SUM_W'(CRAPS_A)) || (sum_q == SUM_W'(CRAPS_B)) ||
                        (sum_q == SUM_W'(CRAPS_C));

    // Natural is tested before craps so overlapping rule sums resolve to a win.
    always_comb begin
        state_d      = state_q;
        point_d      = point_q;
        roll_count_d = roll_count_q;
        win_count_d  = win_count_q;
        loss_count_d = loss_count_q;
        if (stage2_q) begin
            if (state_q == ST_POINT) begin
                roll_count_d = sat_inc(roll_count_q);
                if (sum_q == point_q) begin
                    state_d     = ST_WIN;
                    point_d     = '0;
                    win_count_d = sat_inc(win_count_q);
                end else if (sum_q == SUM_W'(SEVEN_OUT)) begin
                    state_d      = ST_LOSE;
                    point_d      = '0;
                    loss_count_d = sat_inc(loss_count_q);
                end
            end else begin
                roll_count_d = sat_inc((state_q == ST_COME_OUT) ? roll_count_q : '0);
                if (is_natural) begin
                    state_d     = ST_WIN;
                    point_d     = '0;
                    win_count_d = sat_inc(win_count_q);
                end else if (is_craps) begin
                    state_d      = ST_LOSE;
                    point_d      = '0;
                    loss_count_d = sat_inc(loss_count_q);
                end else begin
                    state_d = ST_POINT;
                    point_d = sum_q;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
            stage1_q     <= 1'b0;
            stage2_q     <= 1'b0;
            dice_q       <= {NUM_DICE{DIE_W'(BLANK_DIE)}};
            sum_q        <= '0;
            point_q      <= '0;
            state_q      <= ST_COME_OUT;
            roll_count_q <= '0;
            win_count_q  <= '0;
            loss_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            edge_q       <= edge_d;
            stage1_q     <= stage1_d;
            stage2_q     <= stage2_d;
            dice_q       <= dice_d;
            sum_q        <= sum_d;
            point_q      <= point_d;
            state_q      <= state_d;
            roll_count_q <= roll_count_d;
            win_count_q  <= win_count_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign dice       = dice_q;
    assign sum        = sum_q;
    assign point      = point_q;
    assign status     = state_q;
    assign win        = (state_q == ST_WIN);
    assign loss       = (state_q == ST_LOSE);
    assign roll_count = roll_count_q;
    assign win_count  = win_count_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_craps_engine_n.sv
// tb/tb_craps_engine_n.sv - scoreboard bench for craps_engine_n (default and 3x4-die builds)
module tb_craps_engine_n;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic       roll_a = 1'b0, force_en_a = 1'b0;
    logic [5:0] force_dice_a = '0;
    logic [5:0] dice_a;
    logic [3:0] sum_a, point_a;
    logic [1:0] status_a;
    logic       win_a, loss_a, busy_a;
    logic [7:0] roll_count_a, win_count_a, loss_count_a;

    logic       roll_b = 1'b0, force_en_b = 1'b0;
    logic [8:0] force_dice_b = '0;
    logic [8:0] dice_b;
    logic [3:0] sum_b, point_b;
    logic [1:0] status_b;
    logic       win_b, loss_b, busy_b;
    logic [1:0] roll_count_b, win_count_b, loss_count_b;

    always #5 clock = ~clock;

    craps_engine_n u_dut_a (
        .clock(clock), .reset(reset), .roll(roll_a), .force_en(force_en_a),
        .force_dice(force_dice_a), .dice(dice_a), .sum(sum_a), .point(point_a),
        .status(status_a), .win(win_a), .loss(loss_a), .busy(busy_a),
        .roll_count(roll_count_a), .win_count(win_count_a), .loss_count(loss_count_a)
    );

    craps_engine_n #(.NUM_DICE(3), .DIE_FACES(4), .CNT_W(2)) u_dut_b (
        .clock(clock), .reset(reset), .roll(roll_b), .force_en(force_en_b),
        .force_dice(force_dice_b), .dice(dice_b), .sum(sum_b), .point(point_b),
        .status(status_b), .win(win_b), .loss(loss_b), .busy(busy_b),
        .roll_count(roll_count_b), .win_count(win_count_b), .loss_count(loss_count_b)
    );

    typedef struct {
        int dice; int sum; int st; int pt; int rc; int wc; int lc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected-result model for the default build.
    int m_st = 0, m_pt = 0, m_rc = 0, m_wc = 0, m_lc = 0;
    int b_wc = 0;

    task automatic model_a(input int d0, input int d1);
        exp_t e;
        int   s;
        s = d0 + d1;
        if (m_st == 1) begin
            m_rc = (m_rc == 255) ? 255 : m_rc + 1;
            if (s == m_pt) begin
                m_st = 2; m_pt = 0; m_wc = (m_wc == 255) ? 255 : m_wc + 1;
            end else if (s == 7) begin
                m_st = 3; m_pt = 0; m_lc = (m_lc == 255) ? 255 : m_lc + 1;
            end
        end else begin
            if (m_st != 0) m_rc = 0;
            m_rc = (m_rc == 255) ? 255 : m_rc + 1;
            if (s == 7 || s == 11) begin
                m_st = 2; m_wc = (m_wc == 255) ? 255 : m_wc + 1;
            end else if (s == 2 || s == 3 || s == 12) begin
                m_st = 3; m_lc = (m_lc == 255) ? 255 : m_lc + 1;
            end else begin
                m_st = 1; m_pt = s;
            end
        end
        e.dice = d1 * 8 + d0; e.sum = s; e.st = m_st; e.pt = m_pt;
        e.rc = m_rc; e.wc = m_wc; e.lc = m_lc;
        sb_a.push_back(e);
    endtask

    int  a_len = 0, b_len = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            a_prev = 1'b0; a_len = 0;
        end else begin
            if (busy_a) a_len++;
            else if (a_prev) begin
                check("a_busy_len", a_len, 2);
                check("a_sb_level", sb_a.size(), 1);
                if (sb_a.size() != 0) begin
                    e = sb_a.pop_front();
                    check("a_dice", dice_a, e.dice);
                    check("a_sum", sum_a, e.sum);
                    check("a_status", status_a, e.st);
                    check("a_point", point_a, e.pt);
                    check("a_win", win_a, e.st == 2);
                    check("a_loss", loss_a, e.st == 3);
                    check("a_roll_count", roll_count_a, e.rc);
                    check("a_win_count", win_count_a, e.wc);
                    check("a_loss_count", loss_count_a, e.lc);
                end
                a_len = 0;
            end
            a_prev = busy_a;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            b_prev = 1'b0; b_len = 0;
        end else begin
            if (busy_b) b_len++;
            else if (b_prev) begin
                check("b_busy_len", b_len, 2);
                check("b_sb_level", sb_b.size(), 1);
                if (sb_b.size() != 0) begin
                    e = sb_b.pop_front();
                    check("b_dice", dice_b, e.dice);
                    check("b_sum", sum_b, e.sum);
                    check("b_status", status_b, e.st);
                    check("b_point", point_b, e.pt);
                    check("b_roll_count", roll_count_b, e.rc);
                    check("b_win_count", win_count_b, e.wc);
                    check("b_loss_count", loss_count_b, e.lc);
                end
                b_len = 0;
            end
            b_prev = busy_b;
        end
    end

    task automatic drain_a();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock); #1;
            if (sb_a.size() == 0) break;
        end
        check("a_drain", sb_a.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    // glitch=1 re-presses while the first roll is in flight, then holds the button.
    task automatic roll_a_task(input int d0, input int d1, input int hold, input bit glitch);
        @(negedge clock);
        force_dice_a = {3'(d1), 3'(d0)};
        force_en_a   = 1'b1;
        model_a(d0, d1);
        roll_a = 1'b1;
        if (glitch) begin
            @(negedge clock); roll_a = 1'b0;
            @(negedge clock); roll_a = 1'b1;
        end
        repeat (hold) @(negedge clock);
        roll_a = 1'b0;
        drain_a();
    endtask

    task automatic roll_b_win();
        exp_t e;
        @(negedge clock);
        force_dice_b = {3'd4, 3'd2, 3'd1};
        force_en_b   = 1'b1;
        b_wc = (b_wc == 3) ? 3 : b_wc + 1;
        e.dice = 4 * 64 + 2 * 8 + 1; e.sum = 7; e.st = 2; e.pt = 0;
        e.rc = 1; e.wc = b_wc; e.lc = 0;
        sb_b.push_back(e);
        roll_b = 1'b1;
        repeat (3) @(negedge clock);
        roll_b = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock); #1;
            if (sb_b.size() == 0) break;
        end
        check("b_drain", sb_b.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        int waited;

        #1;
        check("rst_dice", dice_a, 0);
        check("rst_sum", sum_a, 0);
        check("rst_status", status_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_counts", {roll_count_a, win_count_a, loss_count_a}, 0);

        // Die chain of the 3x4 build, free-running from reset release.
        repeat (2) @(negedge clock);
        reset = 1'b1;
        c0 = 1; c1 = 1; c2 = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("b_chain", u_dut_b.u_chain.dice_o, c2 * 64 + c1 * 8 + c0);
            @(negedge clock);
            if (c0 == 4) begin
                c0 = 1;
                if (c1 == 4) begin
                    c1 = 1;
                    c2 = (c2 == 4) ? 1 : c2 + 1;
                end else c1++;
            end else c0++;
        end

        for (int k = 0; k < 4; k++) roll_b_win();

        roll_a_task(3, 4, 3, 1'b0);
        roll_a_task(1, 1, 3, 1'b0);
        roll_a_task(6, 6, 3, 1'b0);
        roll_a_task(2, 3, 3, 1'b0);
        roll_a_task(1, 3, 3, 1'b0);
        roll_a_task(4, 1, 3, 1'b0);
        roll_a_task(2, 3, 3, 1'b0);
        roll_a_task(3, 4, 3, 1'b0);
        roll_a_task(2, 2, 50, 1'b1);
        roll_a_task(6, 1, 3, 1'b0);

        // Abort a roll two cycles into the pipeline with an asynchronous reset.
        @(negedge clock);
        force_dice_a = {3'd5, 3'd6};
        roll_a = 1'b1;
        waited = 0;
        while (!busy_a && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("abort_busy_seen", busy_a, 1);
        @(negedge clock);
        #2;
        reset  = 1'b0;
        roll_a = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_status", status_a, 0);
        check("abort_dice", dice_a, 0);
        check("abort_sum", sum_a, 0);
        check("abort_point", point_a, 0);
        check("abort_winloss", {win_a, loss_a}, 0);
        check("abort_counts", {roll_count_a, win_count_a, loss_count_a}, 0);
        check("abort_b_counts", win_count_b, 0);
        m_st = 0; m_pt = 0; m_rc = 0; m_wc = 0; m_lc = 0; b_wc = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        check("abort_discarded", roll_count_a, 0);

        roll_a_task(5, 6, 3, 1'b0);

        check("final_sb_a", sb_a.size(), 0);
        check("final_sb_b", sb_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
